// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder shared types and constants.
// State encoding and slice width used by the adder and its interface.
package nsa_pkg;

    localparam int NIB_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle between a client and nibble_serial_adder.
// The client drives the operands; the adder returns status and result.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    import nsa_pkg::*;

    localparam int W = NIB_W * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/nibble_serial_adder_cla4.sv
// 4-bit carry-lookahead adder slice, purely combinational.
// s[4] is the carry out, s[3:0] the nibble sum.
module cla4_slice
    import nsa_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W:0]   s
);

    logic [NIB_W-1:0] w_g;
    logic [NIB_W-1:0] w_p;
    logic [NIB_W:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Flattened lookahead carries, each from cin and the g/p terms only.
    always_comb begin
        w_c[0] = cin;
        w_c[1] = w_g[0] | (w_p[0] & cin);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & cin);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);
    end

    assign s = {w_c[NIB_W], w_p ^ w_c[NIB_W-1:0]};

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit CLA slice, one nibble per clock,
// LSB nibble first, with the carry held in a register between steps.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input logic                  clk,
    input logic                  rst,
    nibble_serial_adder_if.slave bus
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int SH    = $clog2(NIB_W);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    state_t            r_state;
    state_t            w_next;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_sum;
    logic              r_c;
    logic              r_cout;
    logic              r_ovf;
    logic              r_done;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W+SH-1:0] w_base;
    logic [NIB_W:0]    w_res;
    logic              w_last;
    logic              w_accept;

    assign w_base   = {r_idx, SH'(0)};
    assign w_last   = (r_idx == LAST);
    assign w_accept = (r_state == IDLE) && bus.start;

    cla4_slice u_slice (
        .a   (r_a[w_base +: NIB_W]),
        .b   (r_b[w_base +: NIB_W]),
        .cin (r_c),
        .s   (w_res)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: run once per accepted start, leave after the top nibble.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand latch, nibble step, and final carry/overflow/done capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sum  <= '0;
            r_c    <= 1'b0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
            r_idx  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a   <= bus.a;
                r_b   <= bus.b;
                r_c   <= bus.cin;
                r_idx <= '0;
            end else if (r_state == RUN) begin
                r_sum[w_base +: NIB_W] <= w_res[NIB_W-1:0];
                r_c <= w_res[NIB_W];
                if (w_last) begin
                    r_cout <= w_res[NIB_W];
                    r_ovf  <= (r_a[W-1] == r_b[W-1]) &&
                              (w_res[NIB_W-1] != r_a[W-1]);
                    r_done <= 1'b1;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at NIBBLES = 4, 1 and 8.
// Expected results are queued at each accepted start, popped on done.
module tb_nibble_serial_adder;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.NIBBLES(4)) if4 ();
    nibble_serial_adder_if #(.NIBBLES(1)) if1 ();
    nibble_serial_adder_if #(.NIBBLES(8)) if8 ();

    nibble_serial_adder #(.NIBBLES(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
    nibble_serial_adder #(.NIBBLES(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    nibble_serial_adder #(.NIBBLES(8)) u8 (.clk(clk), .rst(rst), .bus(if8));

    exp_t q4[$];
    exp_t q1[$];
    exp_t q8[$];
    exp_t e4, e1, e8;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input int w);
        exp_t        r;
        logic [64:0] f;
        logic [63:0] m;
        m   = (64'd1 << w) - 64'd1;
        f   = {1'b0, a & m} + {1'b0, b & m} + {64'd0, ci};
        r.s = f[63:0] & m;
        r.c = f[w];
        r.o = (a[w-1] == b[w-1]) && (f[w-1] != a[w-1]);
        return r;
    endfunction

    // Push expectations on accepted starts; reset abandons in-flight work.
    always @(posedge clk) begin
        if (rst) begin
            q4.delete();
            q1.delete();
            q8.delete();
        end else begin
            if (if4.start && !if4.busy) q4.push_back(model(64'(if4.a), 64'(if4.b), if4.cin, 16));
            if (if1.start && !if1.busy) q1.push_back(model(64'(if1.a), 64'(if1.b), if1.cin, 4));
            if (if8.start && !if8.busy) q8.push_back(model(64'(if8.a), 64'(if8.b), if8.cin, 32));
        end
    end

    // Pop and compare on each done pulse.
    always @(negedge clk) begin
        if (if4.done) begin
            if (q4.size() == 0) chk("dut4_spurious_done", 64'(if4.done), 64'd0);
            else begin
                e4 = q4.pop_front();
                chk("dut4_sum", 64'(if4.sum), e4.s);
                chk("dut4_cout", 64'(if4.cout), 64'(e4.c));
                chk("dut4_ovf", 64'(if4.ovf), 64'(e4.o));
            end
        end
        if (if1.done) begin
            if (q1.size() == 0) chk("dut1_spurious_done", 64'(if1.done), 64'd0);
            else begin
                e1 = q1.pop_front();
                chk("dut1_sum", 64'(if1.sum), e1.s);
                chk("dut1_cout", 64'(if1.cout), 64'(e1.c));
                chk("dut1_ovf", 64'(if1.ovf), 64'(e1.o));
            end
        end
        if (if8.done) begin
            if (q8.size() == 0) chk("dut8_spurious_done", 64'(if8.done), 64'd0);
            else begin
                e8 = q8.pop_front();
                chk("dut8_sum", 64'(if8.sum), e8.s);
                chk("dut8_cout", 64'(if8.cout), 64'(e8.c));
                chk("dut8_ovf", 64'(if8.ovf), 64'(e8.o));
            end
        end
    end

    task automatic op4(input logic [15:0] a, input logic [15:0] b,
                       input logic ci, output int lat);
        @(negedge clk);
        if4.a = a; if4.b = b; if4.cin = ci; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        lat = 0;
        while (!if4.done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op1(input logic [3:0] a, input logic [3:0] b,
                       input logic ci, output int lat);
        @(negedge clk);
        if1.a = a; if1.b = b; if1.cin = ci; if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        lat = 0;
        while (!if1.done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op8(input logic [31:0] a, input logic [31:0] b,
                       input logic ci, output int lat);
        @(negedge clk);
        if8.a = a; if8.b = b; if8.cin = ci; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        lat = 0;
        while (!if8.done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int dn[$];
        int seen;

        rst = 1'b1;
        if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(if4.busy), 64'd0);
        chk("rst_done", 64'(if4.done), 64'd0);
        chk("rst_sum", 64'(if4.sum), 64'd0);
        chk("rst_cout", 64'(if4.cout), 64'd0);
        chk("rst_ovf", 64'(if4.ovf), 64'd0);

        op4(16'hFFFF, 16'h0001, 1'b0, lat);
        chk("ffff_lat", 64'(lat), 64'd4);
        chk("ffff_sum", 64'(if4.sum), 64'h0000);
        chk("ffff_cout", 64'(if4.cout), 64'd1);
        chk("ffff_ovf", 64'(if4.ovf), 64'd0);
        chk("ffff_busy", 64'(if4.busy), 64'd0);

        op4(16'h7FFF, 16'h0001, 1'b0, lat);
        chk("7fff_sum", 64'(if4.sum), 64'h8000);
        chk("7fff_cout", 64'(if4.cout), 64'd0);
        chk("7fff_ovf", 64'(if4.ovf), 64'd1);

        op4(16'h1234, 16'h4321, 1'b1, lat);
        chk("1234_sum", 64'(if4.sum), 64'h5556);
        chk("1234_cout", 64'(if4.cout), 64'd0);
        chk("1234_ovf", 64'(if4.ovf), 64'd0);

        // start held high; operands scrambled whenever the adder is busy
        @(negedge clk);
        if4.a = 16'h0F0F; if4.b = 16'h00F1; if4.cin = 1'b0; if4.start = 1'b1;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            if (if4.done) begin
                dn.push_back(t);
                chk("b2b_sum", 64'(if4.sum), 64'h1000);
            end
            if (if4.busy) begin
                if4.a = 16'($urandom);
                if4.b = 16'($urandom);
            end else begin
                if4.a = 16'h0F0F;
                if4.b = 16'h00F1;
            end
        end
        if4.start = 1'b0;
        chk("b2b_count", 64'(dn.size()), 64'd3);
        if (dn.size() >= 3) begin
            chk("b2b_gap0", 64'(dn[1] - dn[0]), 64'd5);
            chk("b2b_gap1", 64'(dn[2] - dn[1]), 64'd5);
        end
        repeat (8) @(negedge clk);

        op4(16'h8000, 16'h8000, 1'b0, lat);
        chk("pre_rst_cout", 64'(if4.cout), 64'd1);

        // reset lands on the second RUN cycle
        @(negedge clk);
        if4.a = 16'h1234; if4.b = 16'h1111; if4.cin = 1'b0; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(if4.busy), 64'd0);
        chk("midrst_done", 64'(if4.done), 64'd0);
        chk("midrst_sum", 64'(if4.sum), 64'd0);
        chk("midrst_cout", 64'(if4.cout), 64'd0);
        chk("midrst_ovf", 64'(if4.ovf), 64'd0);
        seen = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (if4.done) seen++;
        end
        chk("midrst_no_done", 64'(seen), 64'd0);

        op4(16'h8000, 16'h8000, 1'b0, lat);
        chk("8000_sum", 64'(if4.sum), 64'h0000);
        chk("8000_cout", 64'(if4.cout), 64'd1);
        chk("8000_ovf", 64'(if4.ovf), 64'd1);

        op1(4'hF, 4'h1, 1'b1, lat);
        chk("n1_lat", 64'(lat), 64'd1);
        chk("n1_sum", 64'(if1.sum), 64'h1);
        chk("n1_cout", 64'(if1.cout), 64'd1);

        op8(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, lat);
        chk("n8_lat", 64'(lat), 64'd8);
        chk("n8_wrap_sum", 64'(if8.sum), 64'h0);
        op8(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, lat);
        op8(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
        for (int n = 0; n < 1000; n++) begin
            op8($urandom, $urandom, 1'($urandom), lat);
            if (lat >= 50) chk("n8_timeout", 64'(lat), 64'd8);
        end

        repeat (4) @(negedge clk);
        chk("q4_drained", 64'(q4.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q8_drained", 64'(q8.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
